// File: rtl/truth_table_scanner_pkg.sv
// truth_table_scanner_pkg: shared FSM encodings, default golden table and counter width
package truth_table_scanner_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam logic [15:0] F_GOLDEN = 16'h212F;
  localparam int SETTLE_W = 4;
endpackage

// File: rtl/truth_table_scanner_if.sv
// truth_table_scanner_if: control/result bundle between a scan requester and the scanner
interface truth_table_scanner_if #(parameter int N_IN = 4);
  logic start;
  logic f_s;
  logic [N_IN-1:0] vec;
  logic busy;
  logic done;
  logic [2**N_IN-1:0] tbl;
  logic [N_IN:0] err_count;
  logic pass;
  modport master (output start, f_s, input vec, busy, done, tbl, err_count, pass);
  modport slave (input start, f_s, output vec, busy, done, tbl, err_count, pass);
endinterface

// File: rtl/settle_timer.sv
// settle_timer: per-vector hold counter; tc flags that the vector has been held SETTLE extra cycles
module settle_timer
  import truth_table_scanner_pkg::*;
#(
  parameter int SETTLE = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic tc
);
  logic [SETTLE_W-1:0] cnt;
  assign tc = cnt == SETTLE_W'(SETTLE);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= '0;
    else if (en && !tc) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/truth_table_scanner.sv
// truth_table_scanner: drives every input vector of f, captures its truth table and checks it against EXPECTED
// SCAN_STOP_ON_ERR_EN: when defined, the first mismatch ends the scan with vec left at the failing index
module truth_table_scanner
  import truth_table_scanner_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int SETTLE = 0,
  parameter logic [2**N_IN-1:0] EXPECTED = F_GOLDEN
) (
  input logic clk,
  input logic rst_n,
  truth_table_scanner_if.slave io
);
  localparam int T = 2**N_IN;
  state_t state;
  logic tc, last, mis, stop;
  logic [N_IN:0] err_n;
  assign last = io.vec == N_IN'(T - 1);
  assign mis = io.f_s != EXPECTED[io.vec];
  assign err_n = io.err_count == (N_IN+1)'(T) ? io.err_count : io.err_count + (N_IN+1)'(mis);
`ifdef SCAN_STOP_ON_ERR_EN
  assign stop = last | mis;
`else
  assign stop = last;
`endif
  settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load ((state == IDLE && io.start) || (state == RUN && tc)),
    .en   (state == RUN),
    .tc   (tc)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      io.vec <= '0;
      io.busy <= 1'b0;
      io.done <= 1'b0;
      io.tbl <= '0;
      io.err_count <= '0;
      io.pass <= 1'b0;
    end else begin
      case (state)
        IDLE: if (io.start) begin
          state <= RUN;
          io.vec <= '0;
          io.tbl <= '0;
          io.err_count <= '0;
          io.pass <= 1'b0;
          io.busy <= 1'b1;
        end
        RUN: if (tc) begin
          io.tbl[io.vec] <= io.f_s;
          io.err_count <= err_n;
          if (stop) begin
            state <= DONE;
            io.busy <= 1'b0;
            io.done <= 1'b1;
            io.pass <= err_n == '0;
          end else io.vec <= io.vec + 1'b1;
        end
        DONE: begin
          io.done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_truth_table_scanner.sv
// tb_truth_table_scanner: scoreboard bench with a SETTLE=0 instance (a) and a SETTLE=2 instance (b)
module tb_truth_table_scanner;
  localparam logic [15:0] GOLD = 16'h212F;
  typedef struct {
    logic [15:0] tbl;
    logic [4:0] err;
    logic pass;
    int lat;
    logic [3:0] vec;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int mode_a = 0, mode_b = 0;
  int total = 0, bad = 0;
  exp_t sb[$];
  always #5 clk = ~clk;
  truth_table_scanner_if #(.N_IN(4)) a ();
  truth_table_scanner_if #(.N_IN(4)) b ();
  truth_table_scanner #(.N_IN(4), .SETTLE(0), .EXPECTED(GOLD)) dut_a (.clk(clk), .rst_n(rst_n), .io(a));
  truth_table_scanner #(.N_IN(4), .SETTLE(2), .EXPECTED(GOLD)) dut_b (.clk(clk), .rst_n(rst_n), .io(b));
  // mode 0 golden f, 1 tied low, 2 tied high, 3 golden with vec 5 inverted
  function automatic logic fm(int mode, logic [3:0] v);
    logic g;
    g = GOLD[v];
    return mode == 1 ? 1'b0 : mode == 2 ? 1'b1 : mode == 3 ? g ^ (v == 4'd5) : g;
  endfunction
  assign a.f_s = fm(mode_a, a.vec);
  assign b.f_s = fm(mode_b, b.vec);
  function automatic exp_t model(int mode, int settle);
    exp_t e;
    e.tbl = '0;
    e.err = '0;
    e.vec = '0;
    for (int i = 0; i < 16; i++) begin
      logic f;
      f = fm(mode, 4'(i));
      e.tbl[i] = f;
      e.vec = 4'(i);
      if (f !== GOLD[i]) e.err = e.err + 5'd1;
`ifdef SCAN_STOP_ON_ERR_EN
      if (f !== GOLD[i]) break;
`endif
    end
    e.lat = (int'(e.vec) + 1) * (settle + 1) + 1;
    e.pass = e.err == 0;
    return e;
  endfunction
  task automatic kick(input bit sel, input bit hold);
    @(negedge clk);
    if (sel) b.start = 1'b1;
    else a.start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) begin
      a.start = 1'b0;
      b.start = 1'b0;
    end
  endtask
  // edge numbering: the edge just before the call is 1; lat=-1 on timeout
  task automatic wait_done(input bit sel, input int poke, output int lat);
    lat = -1;
    for (int e = 2; e <= 400; e++) begin
      @(posedge clk);
      #1;
      if (poke > 0) b.start = (e == poke - 1);
      if (sel ? b.done : a.done) begin
        lat = e;
        break;
      end
    end
  endtask
  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    total++; if (a.vec !== 4'd0) begin bad++; $display("FAIL reset_vec got=%0d exp=0", a.vec); end
    total++; if (a.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", a.busy); end
    total++; if (a.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", a.done); end
    total++; if (a.tbl !== 16'h0) begin bad++; $display("FAIL reset_tbl got=%h exp=0000", a.tbl); end
    total++; if (a.err_count !== 5'd0) begin bad++; $display("FAIL reset_err got=%0d exp=0", a.err_count); end
    total++; if (a.pass !== 1'b0) begin bad++; $display("FAIL reset_pass got=%b exp=0", a.pass); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_golden;
    exp_t x;
    int lat;
    mode_a = 0;
    sb.push_back(model(0, 0));
    kick(0, 0);
    wait_done(0, 0, lat);
    x = sb.pop_front();
    total++; if (lat !== x.lat) begin bad++; $display("FAIL golden_lat got=%0d exp=%0d", lat, x.lat); end
    total++; if (a.tbl !== x.tbl) begin bad++; $display("FAIL golden_tbl got=%h exp=%h", a.tbl, x.tbl); end
    total++; if (a.err_count !== x.err) begin bad++; $display("FAIL golden_err got=%0d exp=%0d", a.err_count, x.err); end
    total++; if (a.pass !== x.pass) begin bad++; $display("FAIL golden_pass got=%b exp=%b", a.pass, x.pass); end
    total++; if (a.vec !== x.vec) begin bad++; $display("FAIL golden_vec got=%0d exp=%0d", a.vec, x.vec); end
    total++; if (a.busy !== 1'b0) begin bad++; $display("FAIL golden_busy got=%b exp=0", a.busy); end
    @(posedge clk);
    #1;
    total++; if (a.done !== 1'b0) begin bad++; $display("FAIL golden_done_pulse got=%b exp=0", a.done); end
    total++; if (a.pass !== x.pass) begin bad++; $display("FAIL golden_pass_hold got=%b exp=%b", a.pass, x.pass); end
  endtask
  task automatic test_const;
    exp_t x;
    int lat;
    for (int m = 1; m <= 2; m++) begin
      mode_a = m;
      sb.push_back(model(m, 0));
      kick(0, 0);
      wait_done(0, 0, lat);
      x = sb.pop_front();
      total++; if (lat !== x.lat) begin bad++; $display("FAIL const%0d_lat got=%0d exp=%0d", m, lat, x.lat); end
      total++; if (a.tbl !== x.tbl) begin bad++; $display("FAIL const%0d_tbl got=%h exp=%h", m, a.tbl, x.tbl); end
      total++; if (a.err_count !== x.err) begin bad++; $display("FAIL const%0d_err got=%0d exp=%0d", m, a.err_count, x.err); end
      total++; if (a.pass !== x.pass) begin bad++; $display("FAIL const%0d_pass got=%b exp=%b", m, a.pass, x.pass); end
      @(posedge clk);
    end
  endtask
  task automatic test_settle;
    exp_t x;
    int lat;
    mode_b = 0;
    sb.push_back(model(0, 2));
    kick(1, 0);
    wait_done(1, 10, lat);
    x = sb.pop_front();
    total++; if (lat !== x.lat) begin bad++; $display("FAIL settle_lat got=%0d exp=%0d", lat, x.lat); end
    total++; if (b.tbl !== x.tbl) begin bad++; $display("FAIL settle_tbl got=%h exp=%h", b.tbl, x.tbl); end
    total++; if (b.err_count !== x.err) begin bad++; $display("FAIL settle_err got=%0d exp=%0d", b.err_count, x.err); end
    total++; if (b.pass !== x.pass) begin bad++; $display("FAIL settle_pass got=%b exp=%b", b.pass, x.pass); end
    @(posedge clk);
  endtask
  task automatic test_mid_reset;
    exp_t x;
    int lat;
    mode_a = 0;
    kick(0, 0);
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (a.vec !== 4'd0) begin bad++; $display("FAIL midrst_vec got=%0d exp=0", a.vec); end
    total++; if (a.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", a.busy); end
    total++; if (a.tbl !== 16'h0) begin bad++; $display("FAIL midrst_tbl got=%h exp=0000", a.tbl); end
    total++; if (a.err_count !== 5'd0) begin bad++; $display("FAIL midrst_err got=%0d exp=0", a.err_count); end
    total++; if ({a.done, a.pass} !== 2'b00) begin bad++; $display("FAIL midrst_done_pass got=%b exp=00", {a.done, a.pass}); end
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(model(0, 0));
    kick(0, 0);
    wait_done(0, 0, lat);
    x = sb.pop_front();
    total++; if (lat !== x.lat) begin bad++; $display("FAIL midrst_rescan_lat got=%0d exp=%0d", lat, x.lat); end
    total++; if (a.tbl !== x.tbl) begin bad++; $display("FAIL midrst_rescan_tbl got=%h exp=%h", a.tbl, x.tbl); end
    total++; if (a.pass !== x.pass) begin bad++; $display("FAIL midrst_rescan_pass got=%b exp=%b", a.pass, x.pass); end
    @(posedge clk);
  endtask
  task automatic test_fault;
    exp_t x;
    int lat;
    mode_a = 3;
    sb.push_back(model(3, 0));
    kick(0, 0);
    wait_done(0, 0, lat);
    x = sb.pop_front();
    total++; if (lat !== x.lat) begin bad++; $display("FAIL fault_lat got=%0d exp=%0d", lat, x.lat); end
    total++; if (a.tbl !== x.tbl) begin bad++; $display("FAIL fault_tbl got=%h exp=%h", a.tbl, x.tbl); end
    total++; if (a.err_count !== x.err) begin bad++; $display("FAIL fault_err got=%0d exp=%0d", a.err_count, x.err); end
    total++; if (a.pass !== x.pass) begin bad++; $display("FAIL fault_pass got=%b exp=%b", a.pass, x.pass); end
    total++; if (a.vec !== x.vec) begin bad++; $display("FAIL fault_vec got=%0d exp=%0d", a.vec, x.vec); end
    repeat (2) @(posedge clk);
    #1;
    total++; if (a.vec !== x.vec) begin bad++; $display("FAIL fault_vec_idle got=%0d exp=%0d", a.vec, x.vec); end
  endtask
  task automatic test_back_to_back;
    exp_t x;
    int lat;
    mode_a = 0;
    sb.push_back(model(0, 0));
    sb.push_back(model(0, 0));
    kick(0, 1);
    wait_done(0, 0, lat);
    x = sb.pop_front();
    total++; if (lat !== x.lat) begin bad++; $display("FAIL b2b_first_lat got=%0d exp=%0d", lat, x.lat); end
    total++; if (a.tbl !== x.tbl) begin bad++; $display("FAIL b2b_first_tbl got=%h exp=%h", a.tbl, x.tbl); end
    wait_done(0, 0, lat);
    a.start = 1'b0;
    x = sb.pop_front();
    total++; if (lat !== x.lat + 2) begin bad++; $display("FAIL b2b_second_lat got=%0d exp=%0d", lat, x.lat + 2); end
    total++; if (a.pass !== x.pass) begin bad++; $display("FAIL b2b_second_pass got=%b exp=%b", a.pass, x.pass); end
    repeat (3) @(posedge clk);
    #1;
    total++; if (a.busy !== 1'b0) begin bad++; $display("FAIL b2b_idle_busy got=%b exp=0", a.busy); end
    total++; if (sb.size() != 0) begin bad++; $display("FAIL sb_empty got=%0d exp=0", sb.size()); end
  endtask
  initial begin
    a.start = 1'b0;
    b.start = 1'b0;
    test_reset();
    test_golden();
    test_const();
    test_settle();
    test_mid_reset();
    test_fault();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
